pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match sequencer for the two-player paddle/ball game. Sits beside the VGA display block: it consumes the display's frame sync and lose flags and the player start/pause buttons, and drives game-run enable, ball reset, serve direction, motion speed, scores and winner. It owns the game-level state (idle, serve delay, rally, point pause, pause, game over). The display block owns all per-frame geometry.

## Interface
Parameters:
- WIN_SCORE, 5: points needed to win; range 1–15.
- SERVE_FRAMES, 60: frames of frozen ball before each rally; range 1–255.
- POINT_FRAMES, 90: frames shown after a point before re-serve; range 1–255.
- SPEED_MIN, 1: speed at every serve; range 1–15.
- SPEED_MAX, 4: speed saturation value; SPEED_MIN ≤ SPEED_MAX ≤ 15.
- SPEEDUP_FRAMES, 120: rally frames per +1 speed step; range 1–255.

Ports (name, direction, width, meaning):
- sys_clk, in, 1: system clock. This is the only clock.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- vs, in, 1: vertical sync from the display, active-low. It is asynchronous to sys_clk.
- lose1, lose2, in, 1 each: level flags from the display. lose1=1 means player 1 missed, so the point goes to player 2. lose2 is the mirror.
- start, in, 1: debounced button level.
- pause, in, 1: debounced button level.
- game_run, out, 1: high only in PLAY. It gates ball and paddle motion.
- ball_reset, out, 1: one-cycle pulse that re-centres the ball.
- serve_dir, out, 1: vertical direction of the next serve. 1 means toward player 1.
- speed, out, 4: motion step per frame. It drives bar_move_speed.
- score1, score2, out, 4 each: binary point counts.
- winner, out, 2: 00 none, 01 player 1, 10 player 2.
- state, out, 3: encoded FSM state, for debug.

## Operation
- **Input conditioning:** every input except the clock and reset passes through a 2-FF synchroniser, then a registered edge detector.
  - frame_tick: falling edge of synced vs.
  - lose1_r, lose2_r: rising edges of the synced lose flags.
  - start_r, pause_r: rising edges of the synced buttons.
- **Frame counter:** 8-bit, cleared on every state entry, incremented on frame_tick.
- **FSM states and encodings:** IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5. Unused codes return to IDLE.
- **IDLE:**
  - Holds scores=0, winner=00, speed=SPEED_MIN, serve_dir=0.
  - start_r → SERVE and pulses ball_reset.
- **SERVE:** when the frame counter reaches SERVE_FRAMES (on the tick that makes it equal) → PLAY.
- **PLAY:**
  - lose1_r alone: score2+1, serve_dir=1.
  - lose2_r alone: score1+1, serve_dir=0.
  - lose1_r and lose2_r in the same cycle: no score change, serve_dir unchanged, → POINT.
  - After a score: if the new score equals WIN_SCORE → OVER and winner is set; otherwise → POINT.
  - pause_r → PAUSE. A lose edge in the same cycle takes precedence over pause_r.
  - Every SPEEDUP_FRAMES frame ticks: speed+1, saturating at SPEED_MAX. The speed-up counter is separate from the frame counter and is not cleared by PAUSE.
- **PAUSE:**
  - Frame and speed-up counters are frozen.
  - pause_r → PLAY.
  - start_r and the lose edges are ignored.
- **POINT:** when the frame counter reaches POINT_FRAMES:
  - → SERVE;
  - pulse ball_reset;
  - speed=SPEED_MIN;
  - clear the speed-up counter.
- **OVER:**
  - Scores and winner are held.
  - start_r → IDLE, which clears everything on that transition.
- **Score arithmetic:** 4-bit, never exceeds WIN_SCORE, no wrap.

## Timing
- Every output is registered.
- Reset values: game_run=0, ball_reset=0, serve_dir=0, speed=SPEED_MIN, score1=0, score2=0, winner=00, state=IDLE.
- A sys_rst_n assertion mid-game forces these values immediately (asynchronous) from any state. All counters and synchroniser flops clear.
- Input latency: an input change produces its edge pulse 3 sys_clk cycles later (2 sync + 1 detect). The state/output update follows on the next edge, 4 cycles total.
- game_run and ball_reset change on the same edge as the state register.
- ball_reset is high for exactly one cycle per serve.
- Frame delays count frame_tick pulses, not clocks. SERVE lasts SERVE_FRAMES ticks ±1 frame of alignment.
- A lose level held high produces one score only; it must fall and rise again to score again.

## Test plan
- **Start to rally:** reset, start pulse → ball_reset pulse 4 cycles later, state=1. After 60 vs falls, state=2 and game_run=1.
- **Single point:** in PLAY, raise lose1 →
  - score2=1, serve_dir=1, state=3;
  - 90 frames later, state=1, ball_reset pulse, speed=1.
- **Win:** with WIN_SCORE=5, drive 5 lose2 rises (full SERVE/POINT cycles between them) → score1=5, winner=01, state=5. Start → state=0 and scores 0.
- **Speed and pause:** in PLAY for 480 frames → speed=4 and stays 4.
  - Pause mid-rally → game_run=0 and the counters freeze.
  - Pause again → resumes with the same speed.
- **Simultaneous events:**
  - lose1 and lose2 rise in the same cycle → no score change, state=3.
  - lose1 and pause in the same cycle → score taken, state=3.
- **Async reset mid-POINT:** assert sys_rst_n=0 → all outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Game-level sequencer for the paddle/ball game: conditions the display and button
// inputs, runs the match FSM and drives run enable, ball reset, speed and scores.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned POINT_FRAMES   = 90,
  parameter int unsigned SPEED_MIN      = 1,
  parameter int unsigned SPEED_MAX      = 4,
  parameter int unsigned SPEEDUP_FRAMES = 120
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       vs,
  input  logic       lose1,
  input  logic       lose2,
  input  logic       start,
  input  logic       pause,
  output logic       game_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] speed,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned SYNC_W  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_W-1:0]    sync1, sync2, sync_prev;
  logic                 frame_tick, lose1_r, lose2_r, start_r, pause_r;
  logic [CNT_W-1:0]     frame_cnt, frame_cnt_d, spd_cnt, spd_cnt_d;
  logic                 game_run_d, ball_reset_d, serve_dir_d;
  logic [SPEED_W-1:0]   speed_d;
  logic [SCORE_W-1:0]   score1_d, score2_d;
  logic [1:0]           winner_d;
  logic                 s1_inc, s2_inc, s1_win, s2_win, serve_done, point_done;

  // Two-flop synchroniser followed by a registered edge detector per input
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      sync_prev  <= '0;
      frame_tick <= 1'b0;
      lose1_r    <= 1'b0;
      lose2_r    <= 1'b0;
      start_r    <= 1'b0;
      pause_r    <= 1'b0;
    end else begin
      sync1      <= {vs, lose1, lose2, start, pause};
      sync2      <= sync1;
      sync_prev  <= sync2;
      frame_tick <= sync_prev[4] & ~sync2[4];
      lose1_r    <= sync2[3] & ~sync_prev[3];
      lose2_r    <= sync2[2] & ~sync_prev[2];
      start_r    <= sync2[1] & ~sync_prev[1];
      pause_r    <= sync2[0] & ~sync_prev[0];
    end
  end

  // A simultaneous miss by both players scores nothing
  assign s1_inc     = lose2_r & ~lose1_r;
  assign s2_inc     = lose1_r & ~lose2_r;
  assign s1_win     = s1_inc && (score1 == SCORE_W'(WIN_SCORE - 1));
  assign s2_win     = s2_inc && (score2 == SCORE_W'(WIN_SCORE - 1));
  assign serve_done = frame_tick && (frame_cnt == CNT_W'(SERVE_FRAMES - 1));
  assign point_done = frame_tick && (frame_cnt == CNT_W'(POINT_FRAMES - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_r) state_d = SERVE;
      SERVE: if (serve_done) state_d = PLAY;
      PLAY: begin
        if (lose1_r || lose2_r) state_d = (s1_win || s2_win) ? OVER : POINT;
        else if (pause_r)       state_d = PAUSE;
      end
      PAUSE: if (pause_r) state_d = PLAY;
      POINT: if (point_done) state_d = SERVE;
      OVER:  if (start_r) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    game_run_d   = (state_d == PLAY);
    ball_reset_d = 1'b0;
    serve_dir_d  = serve_dir;
    speed_d      = speed;
    score1_d     = score1;
    score2_d     = score2;
    winner_d     = winner;
    spd_cnt_d    = '0;
    case (state_q)
      IDLE: begin
        serve_dir_d  = 1'b0;
        speed_d      = SPEED_W'(SPEED_MIN);
        score1_d     = '0;
        score2_d     = '0;
        winner_d     = 2'b00;
        ball_reset_d = start_r;
      end
      PLAY: begin
        spd_cnt_d = spd_cnt;
        if (frame_tick) begin
          if (spd_cnt == CNT_W'(SPEEDUP_FRAMES - 1)) begin
            spd_cnt_d = '0;
            if (speed < SPEED_W'(SPEED_MAX)) speed_d = speed + SPEED_W'(1);
          end else begin
            spd_cnt_d = spd_cnt + CNT_W'(1);
          end
        end
        if (s1_inc) begin
          score1_d    = score1 + SCORE_W'(1);
          serve_dir_d = 1'b0;
          if (s1_win) winner_d = 2'b01;
        end
        if (s2_inc) begin
          score2_d    = score2 + SCORE_W'(1);
          serve_dir_d = 1'b1;
          if (s2_win) winner_d = 2'b10;
        end
      end
      PAUSE: spd_cnt_d = spd_cnt;
      POINT: begin
        if (point_done) begin
          ball_reset_d = 1'b1;
          speed_d      = SPEED_W'(SPEED_MIN);
        end
      end
      OVER: begin
        if (start_r) begin
          serve_dir_d = 1'b0;
          speed_d     = SPEED_W'(SPEED_MIN);
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = 2'b00;
        end
      end
      default: ;
    endcase
    // Frame count restarts on every state change and stalls while paused
    if (state_d != state_q)                   frame_cnt_d = '0;
    else if (frame_tick && state_q != PAUSE)  frame_cnt_d = frame_cnt + CNT_W'(1);
    else                                      frame_cnt_d = frame_cnt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      game_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      speed      <= SPEED_W'(SPEED_MIN);
      score1     <= '0;
      score2     <= '0;
      winner     <= 2'b00;
      frame_cnt  <= '0;
      spd_cnt    <= '0;
    end else begin
      game_run   <= game_run_d;
      ball_reset <= ball_reset_d;
      serve_dir  <= serve_dir_d;
      speed      <= speed_d;
      score1     <= score1_d;
      score2     <= score2_d;
      winner     <= winner_d;
      frame_cnt  <= frame_cnt_d;
      spd_cnt    <= spd_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a rule-level match model predicts every change
// of the output bundle and the cycle it appears on; a monitor compares in order.
module tb_pong_match_ctrl;

  localparam int WIN = 5, SF = 60, PF = 90, SMIN = 1, SMAX = 4, SU = 120;
  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_PAUSE = 4, S_OVER = 5;
  localparam logic [19:0] RST_B = {1'b0, 3'd0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 2'd0};

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic vs = 1'b1, lose1 = 1'b0, lose2 = 1'b0, start = 1'b0, pause = 1'b0;
  logic game_run, ball_reset, serve_dir;
  logic [3:0] speed, score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
    .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .SPEEDUP_FRAMES(SU)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .vs(vs), .lose1(lose1), .lose2(lose2),
    .start(start), .pause(pause), .game_run(game_run), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .speed(speed), .score1(score1), .score2(score2),
    .winner(winner), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] b;
    int          stamp;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  function automatic logic [19:0] dut_bundle();
    return {ball_reset, state, game_run, serve_dir, speed, score1, score2, winner};
  endfunction

  // Match model, expressed as the game rules
  int m_st, m_spd, m_s1, m_s2, m_w, m_fc, m_rally;
  bit m_sd;
  logic [19:0] m_last;

  function automatic logic [19:0] m_pack(bit br);
    return {br, 3'(m_st), (m_st == S_PLAY), m_sd, 4'(m_spd), 4'(m_s1), 4'(m_s2), 2'(m_w)};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_spd = SMIN; m_s1 = 0; m_s2 = 0; m_w = 0; m_fc = 0; m_rally = 0;
    m_sd = 1'b0;
    m_last = m_pack(1'b0);
  endtask

  task automatic model_event(input bit st, input bit ps, input bit l1, input bit l2,
                             input bit tk, input int stamp);
    bit br = 1'b0;
    logic [19:0] nb;
    case (m_st)
      S_IDLE: if (st) begin m_st = S_SERVE; m_fc = 0; br = 1'b1; end
      S_SERVE: if (tk) begin
        m_fc++;
        if (m_fc == SF) m_st = S_PLAY;
      end
      S_PLAY: begin
        if (l1 || l2) begin
          if (l1 && !l2) begin m_s2++; m_sd = 1'b1; end
          if (l2 && !l1) begin m_s1++; m_sd = 1'b0; end
          if (m_s1 == WIN)      begin m_st = S_OVER; m_w = 1; end
          else if (m_s2 == WIN) begin m_st = S_OVER; m_w = 2; end
          else begin m_st = S_POINT; m_fc = 0; end
        end else if (ps) begin
          m_st = S_PAUSE;
        end else if (tk) begin
          m_rally++;
          m_spd = SMIN + m_rally / SU;
          if (m_spd > SMAX) m_spd = SMAX;
        end
      end
      S_PAUSE: if (ps) m_st = S_PLAY;
      S_POINT: if (tk) begin
        m_fc++;
        if (m_fc == PF) begin
          m_st = S_SERVE; m_fc = 0; m_rally = 0; m_spd = SMIN; br = 1'b1;
        end
      end
      S_OVER: if (st) begin
        m_st = S_IDLE; m_spd = SMIN; m_s1 = 0; m_s2 = 0; m_w = 0; m_sd = 1'b0; m_rally = 0;
      end
      default: m_st = S_IDLE;
    endcase
    nb = m_pack(br);
    if (nb != m_last) q.push_back('{b: nb, stamp: stamp});
    if (br) q.push_back('{b: m_pack(1'b0), stamp: stamp + 1});
    m_last = m_pack(1'b0);
  endtask

  // Monitor: every change of the output bundle must match the next predicted entry
  logic [19:0] mon_last = RST_B;
  logic [19:0] mon_cur;
  exp_t        mon_e;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      mon_last = RST_B;
    end else begin
      mon_cur = dut_bundle();
      if (mon_cur !== mon_last) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %h at cycle %0d, required no change from %h",
                   mon_cur, cyc, mon_last);
        end else begin
          mon_e = q.pop_front();
          if (mon_cur !== mon_e.b || cyc != mon_e.stamp) begin
            errors++;
            $display("FAIL scoreboard: got %h at cycle %0d, required %h at cycle %0d",
                     mon_cur, cyc, mon_e.b, mon_e.stamp);
          end
        end
        mon_last = mon_cur;
      end
    end
  end

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending entries, required 0 (next %h at cycle %0d)",
               name, q.size(), q[0].b, q[0].stamp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive new button/lose levels; rising levels become model events
  task automatic apply(input logic nst, input logic nps, input logic nl1, input logic nl2);
    bit rs, rp, r1, r2;
    step();
    rs = nst & ~start; rp = nps & ~pause; r1 = nl1 & ~lose1; r2 = nl2 & ~lose2;
    start = nst; pause = nps; lose1 = nl1; lose2 = nl2;
    if (rs || rp || r1 || r2) model_event(rs, rp, r1, r2, 1'b0, cyc + 4);
    repeat (6) step();
  endtask

  task automatic pulse(input logic nst, input logic nps, input logic nl1, input logic nl2);
    apply(nst, nps, nl1, nl2);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      step();
      vs = 1'b0;
      model_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cyc + 4);
      repeat (2) step();
      vs = 1'b1;
      repeat (2) step();
    end
  endtask

  initial begin
    #4_000_000;
    errors++;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int guard;
    model_reset();
    repeat (3) step();
    check("reset_values", dut_bundle(), RST_B);
    sys_rst_n = 1'b1;
    repeat (4) step();

    // Start to rally, single point, re-serve
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    frames(SF);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(PF + SF);

    // Speed ramp to saturation, then pause freezes the ramp
    frames(4 * SU);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    frames(15);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    frames(30);

    // Lose with pause in the same cycle, then both players missing together
    pulse(1'b0, 1'b1, 1'b0, 1'b1);
    frames(PF + SF);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    frames(PF + SF);

    // A lose level held across the next serve scores only once
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    frames(PF + SF + 10);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    frames(5);
    check_drained("held_lose_drain");

    // Player 1 wins, then start returns to idle
    guard = 0;
    while (m_st != S_OVER && guard < 10) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      if (m_st != S_OVER) frames(PF + SF);
      guard++;
    end
    frames(3);
    check("game_over", dut_bundle(), {1'b0, 3'd5, 1'b0, 1'b0, 4'(m_spd), 4'd5, 4'(m_s2), 2'b01});
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("back_to_idle", dut_bundle(), RST_B);

    // Asynchronous reset in the middle of a point pause
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    frames(SF);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(20);
    check_drained("pre_reset_drain");
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("async_reset", dut_bundle(), RST_B);
    model_reset();
    repeat (3) step();
    sys_rst_n = 1'b1;
    repeat (4) step();

    // Randomised play
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 60)      frames(int'($urandom_range(1, 20)));
      else if (r < 70) pulse(1'b1, 1'b0, 1'b0, 1'b0);
      else if (r < 78) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < 87) pulse(1'b0, 1'b0, 1'b1, 1'b0);
      else if (r < 96) pulse(1'b0, 1'b0, 1'b0, 1'b1);
      else             pulse(1'b0, 1'b0, 1'b1, 1'b1);
    end

    repeat (10) step();
    check_drained("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
